// File: rtl/microwave_timer_ctrl.sv
// Microwave controller: countdown cook timer, power duty cycling, door pause/resume, timed bell.
// Optional child lock (extra input lock) is enabled by defining MWAVE_CHILD_LOCK_EN.
module microwave_timer_ctrl #(
    parameter int unsigned TIME_W      = 8,
    parameter int unsigned PWR_W       = 2,
    parameter int unsigned BELL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              door,
    input  logic              start,
    input  logic              cancel,
`ifdef MWAVE_CHILD_LOCK_EN
    input  logic              lock,
`endif
    input  logic              tick,
    input  logic [TIME_W-1:0] time_in,
    input  logic [PWR_W-1:0]  power,
    output logic              heat,
    output logic              light,
    output logic              bell,
    output logic [TIME_W-1:0] remaining,
    output logic              busy
);

    localparam int unsigned BCNT_W = (BELL_CYCLES > 1) ? $clog2(BELL_CYCLES) : 1;
    localparam logic [BCNT_W-1:0] BELL_LAST = BCNT_W'(BELL_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StOpen,
        StCook,
        StPause,
        StHold,
        StBell
    } state_t;

    state_t             state_q, state_d;
    logic [TIME_W-1:0]  rem_q, rem_d;
    logic [PWR_W-1:0]   phase_q, phase_d;
    logic [PWR_W-1:0]   pwr_q, pwr_d;
    logic [BCNT_W-1:0]  bcnt_q, bcnt_d;
    logic               start_ok;

`ifdef MWAVE_CHILD_LOCK_EN
    assign start_ok = start && !lock;
`else
    assign start_ok = start;
`endif

    // Priority: door > cancel > start/tick.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        phase_d = phase_q;
        pwr_d   = pwr_q;
        bcnt_d  = bcnt_q;
        unique case (state_q)
            StIdle: begin
                if (door) begin
                    state_d = StOpen;
                end else if (start_ok && (time_in != '0)) begin
                    state_d = StCook;
                    rem_d   = time_in;
                    pwr_d   = power;
                    phase_d = '0;
                end
            end
            StOpen: begin
                if (!door) state_d = StIdle;
            end
            StCook: begin
                if (door) begin
                    state_d = StPause;
                end else if (cancel) begin
                    state_d = StIdle;
                    rem_d   = '0;
                end else if (tick) begin
                    if (rem_q > TIME_W'(1)) begin
                        rem_d   = rem_q - TIME_W'(1);
                        phase_d = phase_q + PWR_W'(1);
                    end else begin
                        state_d = StBell;
                        rem_d   = '0;
                        bcnt_d  = '0;
                    end
                end
            end
            StPause: begin
                if (!door) state_d = StHold;
            end
            StHold: begin
                if (door) begin
                    state_d = StPause;
                end else if (cancel) begin
                    state_d = StIdle;
                    rem_d   = '0;
                end else if (start_ok) begin
                    state_d = StCook;
                end
            end
            StBell: begin
                if (door) begin
                    state_d = StOpen;
                end else if (cancel) begin
                    state_d = StIdle;
                end else if (bcnt_q == BELL_LAST) begin
                    state_d = StIdle;
                end else begin
                    bcnt_d = bcnt_q + BCNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from next-state values so they register alongside the state.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= StIdle;
            rem_q   <= '0;
            phase_q <= '0;
            pwr_q   <= '0;
            bcnt_q  <= '0;
            heat    <= 1'b0;
            light   <= 1'b0;
            bell    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            phase_q <= phase_d;
            pwr_q   <= pwr_d;
            bcnt_q  <= bcnt_d;
            heat    <= (state_d == StCook) && (phase_d <= pwr_d);
            light   <= (state_d == StOpen) || (state_d == StCook) ||
                       (state_d == StPause) || (state_d == StHold);
            bell    <= (state_d == StBell);
            busy    <= (state_d == StCook) || (state_d == StPause) || (state_d == StHold);
        end
    end

    assign remaining = rem_q;

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed scenarios then random stimulus against a mode model.
module tb_microwave_timer_ctrl;

    localparam int TIME_W = 8;
    localparam int PWR_W  = 2;
    localparam int BELLS  = 4;

    localparam int M_IDLE  = 0;
    localparam int M_OPEN  = 1;
    localparam int M_COOK  = 2;
    localparam int M_PAUSE = 3;
    localparam int M_HOLD  = 4;
    localparam int M_BELL  = 5;

    logic              clk = 1'b0;
    logic              nrst = 1'b0;
    logic              door = 1'b0;
    logic              start = 1'b0;
    logic              cancel = 1'b0;
`ifdef MWAVE_CHILD_LOCK_EN
    logic              lock = 1'b0;
`endif
    logic              tick = 1'b0;
    logic [TIME_W-1:0] time_in = '0;
    logic [PWR_W-1:0]  power = '0;
    logic              heat, light, bell, busy;
    logic [TIME_W-1:0] remaining;

    int nerr = 0;
    int nchk = 0;

    // Reference model state
    int m_mode = M_IDLE;
    int m_rem = 0;
    int m_cooked = 0;
    int m_pwr = 0;
    int m_bell_left = 0;

    microwave_timer_ctrl #(
        .TIME_W(TIME_W),
        .PWR_W(PWR_W),
        .BELL_CYCLES(BELLS)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .door(door),
        .start(start),
        .cancel(cancel),
`ifdef MWAVE_CHILD_LOCK_EN
        .lock(lock),
`endif
        .tick(tick),
        .time_in(time_in),
        .power(power),
        .heat(heat),
        .light(light),
        .bell(bell),
        .remaining(remaining),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_mode = M_IDLE;
        m_rem = 0;
        m_cooked = 0;
        m_pwr = 0;
        m_bell_left = 0;
    endtask

    task automatic m_step();
        logic sok;
        sok = start;
`ifdef MWAVE_CHILD_LOCK_EN
        sok = start && !lock;
`endif
        case (m_mode)
            M_IDLE: begin
                if (door) m_mode = M_OPEN;
                else if (sok && time_in != 0) begin
                    m_mode = M_COOK;
                    m_rem = int'(time_in);
                    m_pwr = int'(power);
                    m_cooked = 0;
                end
            end
            M_OPEN: if (!door) m_mode = M_IDLE;
            M_COOK: begin
                if (door) m_mode = M_PAUSE;
                else if (cancel) begin
                    m_mode = M_IDLE;
                    m_rem = 0;
                end else if (tick) begin
                    if (m_rem == 1) begin
                        m_mode = M_BELL;
                        m_rem = 0;
                        m_bell_left = BELLS;
                    end else begin
                        m_rem = m_rem - 1;
                        m_cooked = m_cooked + 1;
                    end
                end
            end
            M_PAUSE: if (!door) m_mode = M_HOLD;
            M_HOLD: begin
                if (door) m_mode = M_PAUSE;
                else if (cancel) begin
                    m_mode = M_IDLE;
                    m_rem = 0;
                end else if (sok) m_mode = M_COOK;
            end
            default: begin
                if (door) m_mode = M_OPEN;
                else if (cancel) m_mode = M_IDLE;
                else begin
                    m_bell_left = m_bell_left - 1;
                    if (m_bell_left == 0) m_mode = M_IDLE;
                end
            end
        endcase
    endtask

    task automatic check_model();
        logic e_heat;
        e_heat = (m_mode == M_COOK) && ((m_cooked % (1 << PWR_W)) <= m_pwr);
        chk("heat", 32'(heat), 32'(e_heat));
        chk("light", 32'(light), 32'(m_mode inside {M_OPEN, M_COOK, M_PAUSE, M_HOLD}));
        chk("bell", 32'(bell), 32'(m_mode == M_BELL));
        chk("busy", 32'(busy), 32'(m_mode inside {M_COOK, M_PAUSE, M_HOLD}));
        chk("remaining", 32'(remaining), 32'(m_rem));
    endtask

    // One clock: inputs already set; model follows the edge, outputs sampled 1 ns later.
    task automatic cyc();
        @(posedge clk);
        m_step();
        #1;
        check_model();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
    endtask

    task automatic do_start(input int t, input int p);
        time_in = TIME_W'(t);
        power = PWR_W'(p);
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int cnt;
        m_reset();
        #12;
        chk("rst_heat", 32'(heat), 0);
        chk("rst_light", 32'(light), 0);
        chk("rst_bell", 32'(bell), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_remaining", 32'(remaining), 0);
        @(negedge clk);
        nrst = 1'b1;
        cyc();

        // Cook to completion at full power
        do_start(3, 3);
        chk("t1_rem_start", 32'(remaining), 3);
        chk("t1_heat_start", 32'(heat), 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t1_rem_2", 32'(remaining), 2);
        cyc();
        do_tick();
        chk("t1_rem_1", 32'(remaining), 1);
        chk("t1_heat_1", 32'(heat), 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t1_rem_0", 32'(remaining), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (bell) cnt++;
            cyc();
        end
        chk("t1_bell_cycles", 32'(cnt), 4);
        chk("t1_idle_light", 32'(light), 0);

        // Power duty at lowest level
        do_start(8, 0);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (heat) cnt++;
            do_tick();
        end
        chk("t2_heat_periods", 32'(cnt), 2);
        for (int i = 0; i < 6; i++) cyc();

        // Pause and resume across a door opening
        do_start(5, 1);
        do_tick();
        do_tick();
        door = 1'b1;
        cyc();
        chk("t3_pause_light", 32'(light), 1);
        chk("t3_pause_heat", 32'(heat), 0);
        chk("t3_pause_rem", 32'(remaining), 3);
        do_tick();
        do_tick();
        chk("t3_rem_frozen", 32'(remaining), 3);
        door = 1'b0;
        cyc();
        chk("t3_hold_busy", 32'(busy), 1);
        start = 1'b1;
        cyc();
        start = 1'b0;
        do_tick();
        do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t3_bell", 32'(bell), 1);
        for (int i = 0; i < 5; i++) cyc();

        // Simultaneous door, tick and cancel while cooking
        do_start(4, 2);
        door = 1'b1;
        tick = 1'b1;
        cancel = 1'b1;
        cyc();
        tick = 1'b0;
        chk("t4_rem_kept", 32'(remaining), 4);
        chk("t4_busy", 32'(busy), 1);
        door = 1'b0;
        cyc();
        cyc();
        cancel = 1'b0;
        chk("t4_cancel_busy", 32'(busy), 0);
        do_start(0, 1);
        chk("t4_zero_start", 32'(busy), 0);

        // Door opened during the bell
        do_start(1, 3);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        door = 1'b1;
        cyc();
        chk("t5_bell_off", 32'(bell), 0);
        chk("t5_light", 32'(light), 1);
        door = 1'b0;
        cyc();

        // Asynchronous reset mid-cook
        do_start(9, 2);
        do_tick();
        do_tick();
        chk("t6_rem_7", 32'(remaining), 7);
        #2;
        nrst = 1'b0;
        m_reset();
        #1;
        chk("t6_rst_rem", 32'(remaining), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_light", 32'(light), 0);
        door = 1'b1;
        @(negedge clk);
        nrst = 1'b1;
        cyc();
        chk("t6_open_light", 32'(light), 1);
        door = 1'b0;
        cyc();

`ifdef MWAVE_CHILD_LOCK_EN
        lock = 1'b1;
        do_start(3, 1);
        chk("lock_idle", 32'(busy), 0);
        lock = 1'b0;
        cyc();
`endif

        // Random stimulus against the model
        for (int i = 0; i < 800; i++) begin
            door = ($urandom_range(0, 9) == 0);
            cancel = ($urandom_range(0, 15) == 0);
            start = ($urandom_range(0, 3) == 0);
            tick = ($urandom_range(0, 2) == 0);
            time_in = TIME_W'($urandom_range(0, 6));
            power = PWR_W'($urandom_range(0, 3));
`ifdef MWAVE_CHILD_LOCK_EN
            lock = ($urandom_range(0, 7) == 0);
`endif
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
